cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
Parametrised common-data-bus arbiter and broadcast register for the Tomasulo core. It replaces the fixed 4-source CDB and priority helper pair. It takes N functional-unit result channels (ALU, MUL, DIV, LS, ...) and grants at most one per cycle, either round-robin or fixed-priority. The winner's {label, data} is registered onto the broadcast bus consumed by the register file and the reservation stations.

Parameters:
N, 4, number of producer channels (1..16); channel i is bit/slice i of the packed ports
DW, 32, result data width
LW, 4, tag (label) width; label value 0 is reserved for "no producer"
RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority, channel 0 highest

Ports:
clk  in  1  clock
nRST  in  1  asynchronous active-low reset
require  in  N  per-channel request; held high with stable data/label until accepted
data_in  in  N*DW  packed result data, channel i at [i*DW +: DW]
label_in  in  N*LW  packed result tags, channel i at [i*LW +: LW]
accept  out  N  one-hot-or-zero grant, combinational in the request cycle
BCEN  out  1  broadcast valid (registered)
BCdata  out  DW  broadcast data (registered)
BClabel  out  LW  broadcast tag (registered); 0 whenever BCEN=0
label_err  out  1  sticky flag: a request carrying label 0 was granted

Behaviour:
- Reset (async, nRST=0): BCEN=0, BCdata=0, BClabel=0, label_err=0, round-robin pointer ptr=0. accept=0 while nRST=0.
- Grant cycle t:
  - RR_MODE=1: scan require from index ptr upward, wrapping modulo N; the first set bit g wins.
  - RR_MODE=0: lowest set index wins.
  - accept[g]=1; all other accept bits are 0. No request gives accept=0.
  - accept depends only on require, ptr and nRST, never on data/label (no comb loop through producers).
- Broadcast, cycle t+1 (latency 1):
  - BCEN=1, BCdata=data_in[g], BClabel=label_in[g], all sampled at edge t.
  - If there was no grant at t: BCEN=0, BClabel=0, BCdata holds its last value.
- Pointer: on any grant, ptr <= (g+1) mod N; with no grant, ptr holds. In RR_MODE=0, ptr is unused and stays 0.
- Fairness: in RR_MODE=1, a continuously asserted request is granted within N cycles.
- Producer handshake:
  - A producer seeing accept[i]=1 at edge t either drops require[i] or presents its next result at t+1.
  - A producer not accepted keeps require, data and label stable.
  - The arbiter holds no per-channel state beyond ptr.
- Label 0 request: granted and accepted normally (so it drains), but the broadcast is suppressed (BCEN=0, BClabel=0 at t+1) and label_err <= 1. label_err stays set until reset.
- N=1: ptr is a constant 0; the block degenerates to registering channel 0.
- Simultaneous events:
  - Requests from all channels in one cycle: exactly one grant.
  - A grant and reset asserted together: reset wins; no broadcast follows.
- Reset mid-operation: a pending broadcast is lost. Producers must re-request after reset (consumers are reset too).

Decomposition:
- Shared package (tomasulo_pkg): LW default, LABEL_NONE=0, channel index constants CH_ALU=0, CH_MUL=1, CH_DIV=2, CH_LS=3.
- Sub-module cdb_rr_pick: combinational; inputs req[N], ptr, rr_mode; outputs one-hot grant and its binary index. Rotate-then-find-first, parametrised on N.
- Top cdb_arbiter: holds ptr, the broadcast registers, label_err and packed-slice muxing.

Test Plan:
- Reset: hold nRST=0 with require=4'b1111 -> accept=0, BCEN=0, BClabel=0, label_err=0; release -> accept=4'b0001 in the first cycle.
- Single source: N=4, RR_MODE=1, require=4'b0100, label_in[2]=4'd5, data_in[2]=32'hDEADBEEF -> accept=4'b0100 at t; BCEN=1, BClabel=5, BCdata=DEADBEEF at t+1; BCEN=0 at t+2 once require drops.
- Round-robin rotation: require=4'b1111 held for 8 cycles, labels 1..4 -> grant order 0,1,2,3,0,1,2,3; broadcast labels 1,2,3,4,1,2,3,4.
- Fixed priority: RR_MODE=0, require=4'b1010 held -> channel 1 granted every cycle; channel 3 is granted only after require[1] drops.
- Label 0: require=4'b0001 with label 0 -> accept=4'b0001, BCEN stays 0, BClabel=0, label_err=1 and sticky.
- Mid-broadcast reset: grant channel 3 at t, pulse nRST low before edge t+1 -> BCEN=0, ptr=0; next grant with require=4'b1001 goes to channel 0.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared Tomasulo core constants used by the CDB arbiter
// Contents:
//   LW_DEFAULT  default result tag width
//   LABEL_NONE  reserved tag value meaning "no producer"
//   CH_*        conventional channel indices of the functional units
//   idx_width() bits needed to hold a channel index (at least 1)
package tomasulo_pkg;

   localparam int LW_DEFAULT = 4;
   localparam int LABEL_NONE = 0;

   localparam int CH_ALU = 0;
   localparam int CH_MUL = 1;
   localparam int CH_DIV = 2;
   localparam int CH_LS  = 3;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdb_rr_pick.sv
// rtl/cdb_rr_pick.sv - combinational rotate-then-find-first channel picker
// Ports:
//   req      in   N   per-channel request
//   ptr      in   PW  channel that gets first look when rr_mode=1
//   rr_mode  in   1   1 = start scan at ptr, 0 = start scan at channel 0
//   grant    out  N   one-hot-or-zero winner
//   idx      out  PW  binary index of the winner (0 when no request)
//   valid    out  1   some request is present
module cdb_rr_pick
   import tomasulo_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   input  logic          rr_mode,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] idx,
   output logic          valid
);

   logic [PW-1:0] start;
   logic [N-1:0]  rot;
   logic [PW-1:0] src;
   int            off;

   assign start = rr_mode ? ptr : '0;

   // rot[j] is the request of the channel j places after start, so the
   // lowest set bit of rot is the round-robin winner.
   always_comb begin
      rot = '0;
      src = '0;
      for (int j = 0; j < N; j++) begin
         src    = PW'((int'(start) + j) % N);
         rot[j] = req[src];
      end
   end

   // Descending scan so the lowest set offset is the one left standing.
   always_comb begin
      valid = 1'b0;
      off   = 0;
      for (int j = N - 1; j >= 0; j--) begin
         if (rot[j]) begin
            valid = 1'b1;
            off   = j;
         end
      end
   end

   assign idx   = valid ? PW'((int'(start) + off) % N) : '0;
   assign grant = valid ? (N'(1) << idx) : '0;

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common-data-bus arbiter and registered broadcast
// Ports:
//   clk        in   1     clock
//   nRST       in   1     asynchronous active-low reset
//   require    in   N     per-channel request, held with stable data/label
//   data_in    in   N*DW  packed result data, channel i at [i*DW +: DW]
//   label_in   in   N*LW  packed result tags, channel i at [i*LW +: LW]
//   accept     out  N     one-hot-or-zero grant, same cycle as request
//   BCEN       out  1     broadcast valid, one cycle after the grant
//   BCdata     out  DW    broadcast data, holds when nothing broadcasts
//   BClabel    out  LW    broadcast tag, 0 whenever BCEN=0
//   label_err  out  1     sticky: a request with tag 0 was granted
module cdb_arbiter
   import tomasulo_pkg::*;
#(
   parameter int N       = 4,
   parameter int DW      = 32,
   parameter int LW      = LW_DEFAULT,
   parameter int RR_MODE = 1
) (
   input  logic            clk,
   input  logic            nRST,
   input  logic [N-1:0]    require,
   input  logic [N*DW-1:0] data_in,
   input  logic [N*LW-1:0] label_in,
   output logic [N-1:0]    accept,
   output logic            BCEN,
   output logic [DW-1:0]   BCdata,
   output logic [LW-1:0]   BClabel,
   output logic            label_err
);

   localparam int PW = idx_width(N);

   logic [PW-1:0] ptr;
   logic [N-1:0]  g_onehot;
   logic [PW-1:0] g_idx;
   logic          g_valid;
   logic [DW-1:0] sel_data;
   logic [LW-1:0] sel_label;
   logic          sel_none;

   // The grant looks only at require/ptr, so no path runs from a
   // producer's data or label back into its own accept.
   cdb_rr_pick #(
      .N  (N),
      .PW (PW)
   ) u_pick (
      .req     (require),
      .ptr     (ptr),
      .rr_mode (RR_MODE != 0),
      .grant   (g_onehot),
      .idx     (g_idx),
      .valid   (g_valid)
   );

   assign accept    = nRST ? g_onehot : '0;
   assign sel_data  = data_in[int'(g_idx) * DW +: DW];
   assign sel_label = label_in[int'(g_idx) * LW +: LW];
   assign sel_none  = (sel_label == LW'(LABEL_NONE));

   // Pointer moves past the winner on every grant, tag-0 grants included,
   // so a bad producer cannot starve the others. Fixed priority keeps it 0.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         ptr <= '0;
      end else if (RR_MODE != 0 && g_valid) begin
         ptr <= (int'(g_idx) == N - 1) ? '0 : g_idx + PW'(1);
      end
   end

   // A tag-0 result is drained (accepted) but never reaches the bus.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         BCEN      <= 1'b0;
         BCdata    <= '0;
         BClabel   <= '0;
         label_err <= 1'b0;
      end else if (g_valid && !sel_none) begin
         BCEN    <= 1'b1;
         BCdata  <= sel_data;
         BClabel <= sel_label;
      end else begin
         BCEN    <= 1'b0;
         BClabel <= '0;
         if (g_valid) begin
            label_err <= 1'b1;
         end
      end
   end

endmodule
